// File: rtl/rvfi_pkg.sv
// rvfi_pkg: shared definitions for the RVFI channel serializer.
//   - Field widths of one retirement packet (rvfi_valid is not stored).
//   - rvfi_pkt_t: one retirement, XLEN-dependent fields held at 64 bits.
//   - pkt_pack / pkt_unpack: flatten a retirement into the stored packet
//     layout for a given XLEN (order is the least-significant field).
//   - popcount: number of valid lanes in a retirement group.
package rvfi_pkg;

  localparam int ORDER_W   = 8;
  localparam int INSN_W    = 32;
  localparam int REG_W     = 5;
  localparam int XLEN_MAX  = 64;
  localparam int FIXED_W   = ORDER_W + INSN_W + 1 + 3 * REG_W;
  localparam int PKT_W_MAX = FIXED_W + 8 * XLEN_MAX + XLEN_MAX / 4;

  typedef logic [PKT_W_MAX-1:0] pkt_max_t;

  typedef struct packed {
    logic [ORDER_W-1:0]  order;
    logic [INSN_W-1:0]   insn;
    logic                trap;
    logic [REG_W-1:0]    rs1_addr;
    logic [REG_W-1:0]    rs2_addr;
    logic [REG_W-1:0]    rd_addr;
    logic [XLEN_MAX-1:0] rs1_rdata;
    logic [XLEN_MAX-1:0] rs2_rdata;
    logic [XLEN_MAX-1:0] rd_wdata;
    logic [XLEN_MAX-1:0] pc_rdata;
    logic [XLEN_MAX-1:0] pc_wdata;
    logic [XLEN_MAX-1:0] mem_addr;
    logic [7:0]          mem_rmask;
    logic [7:0]          mem_wmask;
    logic [XLEN_MAX-1:0] mem_rdata;
    logic [XLEN_MAX-1:0] mem_wdata;
  } rvfi_pkt_t;

  function automatic int pkt_width(input int xlen);
    return FIXED_W + 8 * xlen + xlen / 4;
  endfunction

  function automatic pkt_max_t fld_mask(input int w);
    return (pkt_max_t'(1) << w) - pkt_max_t'(1);
  endfunction

  function automatic pkt_max_t fld_ins(input pkt_max_t acc, input int off,
                                       input logic [XLEN_MAX-1:0] v, input int w);
    return acc | ((pkt_max_t'(v) & fld_mask(w)) << off);
  endfunction

  function automatic logic [XLEN_MAX-1:0] fld_ext(input pkt_max_t pkt, input int off,
                                                  input int w);
    pkt_max_t s;
    s = (pkt >> off) & fld_mask(w);
    return s[XLEN_MAX-1:0];
  endfunction

  function automatic pkt_max_t pkt_pack(input rvfi_pkt_t p, input int xlen);
    pkt_max_t acc;
    int off;
    acc = '0;
    off = 0;
    acc = fld_ins(acc, off, 64'(p.order), ORDER_W);    off += ORDER_W;
    acc = fld_ins(acc, off, 64'(p.insn), INSN_W);      off += INSN_W;
    acc = fld_ins(acc, off, 64'(p.trap), 1);           off += 1;
    acc = fld_ins(acc, off, 64'(p.rs1_addr), REG_W);   off += REG_W;
    acc = fld_ins(acc, off, 64'(p.rs2_addr), REG_W);   off += REG_W;
    acc = fld_ins(acc, off, 64'(p.rd_addr), REG_W);    off += REG_W;
    acc = fld_ins(acc, off, p.rs1_rdata, xlen);        off += xlen;
    acc = fld_ins(acc, off, p.rs2_rdata, xlen);        off += xlen;
    acc = fld_ins(acc, off, p.rd_wdata, xlen);         off += xlen;
    acc = fld_ins(acc, off, p.pc_rdata, xlen);         off += xlen;
    acc = fld_ins(acc, off, p.pc_wdata, xlen);         off += xlen;
    acc = fld_ins(acc, off, p.mem_addr, xlen);         off += xlen;
    acc = fld_ins(acc, off, 64'(p.mem_rmask), xlen/8); off += xlen / 8;
    acc = fld_ins(acc, off, 64'(p.mem_wmask), xlen/8); off += xlen / 8;
    acc = fld_ins(acc, off, p.mem_rdata, xlen);        off += xlen;
    acc = fld_ins(acc, off, p.mem_wdata, xlen);
    return acc;
  endfunction

  function automatic rvfi_pkt_t pkt_unpack(input pkt_max_t pkt, input int xlen);
    rvfi_pkt_t p;
    int off;
    off = 0;
    p.order     = 8'(fld_ext(pkt, off, ORDER_W));  off += ORDER_W;
    p.insn      = 32'(fld_ext(pkt, off, INSN_W));  off += INSN_W;
    p.trap      = 1'(fld_ext(pkt, off, 1));        off += 1;
    p.rs1_addr  = 5'(fld_ext(pkt, off, REG_W));    off += REG_W;
    p.rs2_addr  = 5'(fld_ext(pkt, off, REG_W));    off += REG_W;
    p.rd_addr   = 5'(fld_ext(pkt, off, REG_W));    off += REG_W;
    p.rs1_rdata = fld_ext(pkt, off, xlen);         off += xlen;
    p.rs2_rdata = fld_ext(pkt, off, xlen);         off += xlen;
    p.rd_wdata  = fld_ext(pkt, off, xlen);         off += xlen;
    p.pc_rdata  = fld_ext(pkt, off, xlen);         off += xlen;
    p.pc_wdata  = fld_ext(pkt, off, xlen);         off += xlen;
    p.mem_addr  = fld_ext(pkt, off, xlen);         off += xlen;
    p.mem_rmask = 8'(fld_ext(pkt, off, xlen/8));   off += xlen / 8;
    p.mem_wmask = 8'(fld_ext(pkt, off, xlen/8));   off += xlen / 8;
    p.mem_rdata = fld_ext(pkt, off, xlen);         off += xlen;
    p.mem_wdata = fld_ext(pkt, off, xlen);
    return p;
  endfunction

  function automatic int popcount(input logic [3:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) n += int'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/rvfi_multi_push_fifo.sv
// rvfi_multi_push_fifo: DEPTH-entry packet buffer accepting up to NRET
// writes and one read per cycle.
//   clk, resetn : clock, asynchronous active-low reset (pointers/count only)
//   wr_cnt      : number of packets to write this cycle (0..NRET)
//   wr_data     : compacted packets, packet k at k*W +: W
//   rd_en       : pop the head entry
//   rd_data     : head entry (valid when count != 0)
//   count       : stored entries
// The caller guarantees no overflow/underflow; occupancy is tracked by the
// counter, so rd_ptr == wr_ptr is ambiguous and never used.
module rvfi_multi_push_fifo #(
  parameter int W     = 320,
  parameter int NRET  = 2,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [$clog2(DEPTH):0]     wr_cnt,
  input  logic [NRET*W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]       mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  // Storage is data-only: no reset, written at consecutive slots from wr_ptr.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NRET; k++) begin
      if (CNT_W'(k) < wr_cnt) mem[wr_ptr + PTR_W'(k)] <= wr_data[k*W +: W];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(wr_cnt);
      rd_ptr <= rd_ptr + PTR_W'(rd_en);
      count  <= count + wr_cnt - CNT_W'(rd_en);
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/rvfi_channel_serializer.sv
// rvfi_channel_serializer: replays up to NRET RVFI retirements per cycle as
// a single-channel RVFI stream, one retirement per cycle, in retire order.
//   clk, resetn   : clock, asynchronous active-low reset
//   rvfi_*        : multi-channel retirement buses, channel i at i*w +: w
//   out_ready     : downstream accepts the current output
//   out_*         : serialized retirement, qualified by out_valid
//   check_en      : output holds order == CHECK_ORDER
//   overflow      : sticky, a retirement group was dropped for lack of space
//   order_err     : sticky, consecutive emitted orders were not +1 (mod 256)
//   count         : occupancy including the entry in the output register
module rvfi_channel_serializer
  import rvfi_pkg::*;
#(
  parameter int NRET        = 2,
  parameter int XLEN        = 32,
  parameter int DEPTH       = 8,
  parameter int CHECK_ORDER = 20
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NRET-1:0]        rvfi_valid,
  input  logic [NRET*8-1:0]      rvfi_order,
  input  logic [NRET*32-1:0]     rvfi_insn,
  input  logic [NRET-1:0]        rvfi_trap,
  input  logic [NRET*5-1:0]      rvfi_rs1_addr,
  input  logic [NRET*5-1:0]      rvfi_rs2_addr,
  input  logic [NRET*XLEN-1:0]   rvfi_rs1_rdata,
  input  logic [NRET*XLEN-1:0]   rvfi_rs2_rdata,
  input  logic [NRET*5-1:0]      rvfi_rd_addr,
  input  logic [NRET*XLEN-1:0]   rvfi_rd_wdata,
  input  logic [NRET*XLEN-1:0]   rvfi_pc_rdata,
  input  logic [NRET*XLEN-1:0]   rvfi_pc_wdata,
  input  logic [NRET*XLEN-1:0]   rvfi_mem_addr,
  input  logic [NRET*XLEN/8-1:0] rvfi_mem_rmask,
  input  logic [NRET*XLEN/8-1:0] rvfi_mem_wmask,
  input  logic [NRET*XLEN-1:0]   rvfi_mem_rdata,
  input  logic [NRET*XLEN-1:0]   rvfi_mem_wdata,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [7:0]             out_order,
  output logic [31:0]            out_insn,
  output logic                   out_trap,
  output logic [4:0]             out_rs1_addr,
  output logic [4:0]             out_rs2_addr,
  output logic [XLEN-1:0]        out_rs1_rdata,
  output logic [XLEN-1:0]        out_rs2_rdata,
  output logic [4:0]             out_rd_addr,
  output logic [XLEN-1:0]        out_rd_wdata,
  output logic [XLEN-1:0]        out_pc_rdata,
  output logic [XLEN-1:0]        out_pc_wdata,
  output logic [XLEN-1:0]        out_mem_addr,
  output logic [XLEN/8-1:0]      out_mem_rmask,
  output logic [XLEN/8-1:0]      out_mem_wmask,
  output logic [XLEN-1:0]        out_mem_rdata,
  output logic [XLEN-1:0]        out_mem_wdata,
  output logic                   check_en,
  output logic                   overflow,
  output logic                   order_err,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PKT_W = pkt_width(XLEN);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [PKT_W-1:0]      lane_pkt_p0 [NRET];
  logic [NRET*PKT_W-1:0] wr_data_p0;
  logic [CNT_W-1:0]      push_n_p0;
  logic [CNT_W-1:0]      wr_cnt_p0;
  logic                  accept_p0;
  logic                  pop;
  logic                  load;
  logic [CNT_W-1:0]      fifo_cnt;
  logic [PKT_W-1:0]      head_pkt;
  logic                  vld_p1;
  logic [PKT_W-1:0]      out_pkt_p1;
  logic [7:0]            exp_order;
  logic                  exp_vld;
  pkt_max_t              out_full;
  rvfi_pkt_t             out_s;

  // ---- Stage p0: per-lane packing, compaction, space check ----
  for (genvar i = 0; i < NRET; i++) begin : g_lane
    rvfi_pkt_t lane_s;
    pkt_max_t  lane_full;
    assign lane_s = '{
      order:     rvfi_order[i*8 +: 8],
      insn:      rvfi_insn[i*32 +: 32],
      trap:      rvfi_trap[i],
      rs1_addr:  rvfi_rs1_addr[i*5 +: 5],
      rs2_addr:  rvfi_rs2_addr[i*5 +: 5],
      rd_addr:   rvfi_rd_addr[i*5 +: 5],
      rs1_rdata: 64'(rvfi_rs1_rdata[i*XLEN +: XLEN]),
      rs2_rdata: 64'(rvfi_rs2_rdata[i*XLEN +: XLEN]),
      rd_wdata:  64'(rvfi_rd_wdata[i*XLEN +: XLEN]),
      pc_rdata:  64'(rvfi_pc_rdata[i*XLEN +: XLEN]),
      pc_wdata:  64'(rvfi_pc_wdata[i*XLEN +: XLEN]),
      mem_addr:  64'(rvfi_mem_addr[i*XLEN +: XLEN]),
      mem_rmask: 8'(rvfi_mem_rmask[i*XLEN/8 +: XLEN/8]),
      mem_wmask: 8'(rvfi_mem_wmask[i*XLEN/8 +: XLEN/8]),
      mem_rdata: 64'(rvfi_mem_rdata[i*XLEN +: XLEN]),
      mem_wdata: 64'(rvfi_mem_wdata[i*XLEN +: XLEN])
    };
    assign lane_full      = pkt_pack(lane_s, XLEN);
    assign lane_pkt_p0[i] = lane_full[PKT_W-1:0];
  end

  // Valid lanes are packed toward slot 0 in ascending lane order, so the
  // oldest retirement lands at wr_ptr. Invalid lanes never reach a slot.
  always_comb begin
    int slot;
    wr_data_p0 = '0;
    slot       = 0;
    for (int i = 0; i < NRET; i++) begin
      if (rvfi_valid[i]) begin
        wr_data_p0[slot*PKT_W +: PKT_W] = lane_pkt_p0[i];
        slot++;
      end
    end
  end

  assign pop       = vld_p1 && out_ready;
  assign push_n_p0 = CNT_W'(popcount(4'(rvfi_valid)));
  // A pop in the same cycle frees a slot, so a full buffer can still take
  // a group that fits in what the pop releases.
  assign accept_p0 = int'(push_n_p0) <= DEPTH - int'(count) + int'(pop);
  assign wr_cnt_p0 = accept_p0 ? push_n_p0 : '0;
  assign load      = (!vld_p1 || pop) && (fifo_cnt != '0);
  assign count     = fifo_cnt + CNT_W'(vld_p1);

  rvfi_multi_push_fifo #(
    .W     (PKT_W),
    .NRET  (NRET),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .wr_cnt  (wr_cnt_p0),
    .wr_data (wr_data_p0),
    .rd_en   (load),
    .rd_data (head_pkt),
    .count   (fifo_cnt)
  );

  // ---- Stage p1: output register, sticky flags, order tracking ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p1     <= 1'b0;
      out_pkt_p1 <= '0;
      overflow   <= 1'b0;
      order_err  <= 1'b0;
      exp_order  <= '0;
      exp_vld    <= 1'b0;
    end else begin
      if (load) begin
        vld_p1     <= 1'b1;
        out_pkt_p1 <= head_pkt;
      end else if (pop) begin
        vld_p1     <= 1'b0;
      end
      if (!accept_p0) overflow <= 1'b1;
      if (pop) begin
        if (exp_vld && out_s.order != exp_order) order_err <= 1'b1;
        exp_order <= out_s.order + 8'd1;
        exp_vld   <= 1'b1;
      end
    end
  end

  assign out_full = pkt_max_t'(out_pkt_p1);
  assign out_s    = pkt_unpack(out_full, XLEN);

  assign out_valid     = vld_p1;
  assign out_order     = out_s.order;
  assign out_insn      = out_s.insn;
  assign out_trap      = out_s.trap;
  assign out_rs1_addr  = out_s.rs1_addr;
  assign out_rs2_addr  = out_s.rs2_addr;
  assign out_rd_addr   = out_s.rd_addr;
  assign out_rs1_rdata = out_s.rs1_rdata[XLEN-1:0];
  assign out_rs2_rdata = out_s.rs2_rdata[XLEN-1:0];
  assign out_rd_wdata  = out_s.rd_wdata[XLEN-1:0];
  assign out_pc_rdata  = out_s.pc_rdata[XLEN-1:0];
  assign out_pc_wdata  = out_s.pc_wdata[XLEN-1:0];
  assign out_mem_addr  = out_s.mem_addr[XLEN-1:0];
  assign out_mem_rmask = out_s.mem_rmask[XLEN/8-1:0];
  assign out_mem_wmask = out_s.mem_wmask[XLEN/8-1:0];
  assign out_mem_rdata = out_s.mem_rdata[XLEN-1:0];
  assign out_mem_wdata = out_s.mem_wdata[XLEN-1:0];

  assign check_en = vld_p1 && (out_s.order == 8'(CHECK_ORDER));

endmodule

// File: tb/tb_rvfi_channel_serializer.sv
module tb_rvfi_channel_serializer;

  localparam int NRET  = 2;
  localparam int XLEN  = 32;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [NRET-1:0]        rvfi_valid;
  logic [NRET*8-1:0]      rvfi_order;
  logic [NRET*32-1:0]     rvfi_insn;
  logic [NRET-1:0]        rvfi_trap;
  logic [NRET*5-1:0]      rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
  logic [NRET*XLEN-1:0]   rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
  logic [NRET*XLEN-1:0]   rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_addr;
  logic [NRET*XLEN/8-1:0] rvfi_mem_rmask, rvfi_mem_wmask;
  logic [NRET*XLEN-1:0]   rvfi_mem_rdata, rvfi_mem_wdata;
  logic                   out_ready;

  logic                   out_valid;
  logic [7:0]             out_order;
  logic [31:0]            out_insn;
  logic                   out_trap;
  logic [4:0]             out_rs1_addr, out_rs2_addr, out_rd_addr;
  logic [XLEN-1:0]        out_rs1_rdata, out_rs2_rdata, out_rd_wdata;
  logic [XLEN-1:0]        out_pc_rdata, out_pc_wdata, out_mem_addr;
  logic [XLEN/8-1:0]      out_mem_rmask, out_mem_wmask;
  logic [XLEN-1:0]        out_mem_rdata, out_mem_wdata;
  logic                   check_en, overflow, order_err;
  logic [CW-1:0]          count;

  int checks = 0;
  int errors = 0;

  rvfi_channel_serializer #(
    .NRET(NRET), .XLEN(XLEN), .DEPTH(DEPTH), .CHECK_ORDER(20)
  ) dut (
    .clk(clk), .resetn(resetn),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
    .rvfi_trap(rvfi_trap), .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
    .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
    .rvfi_mem_wmask(rvfi_mem_wmask), .rvfi_mem_rdata(rvfi_mem_rdata),
    .rvfi_mem_wdata(rvfi_mem_wdata), .out_ready(out_ready),
    .out_valid(out_valid), .out_order(out_order), .out_insn(out_insn),
    .out_trap(out_trap), .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr),
    .out_rs1_rdata(out_rs1_rdata), .out_rs2_rdata(out_rs2_rdata),
    .out_rd_addr(out_rd_addr), .out_rd_wdata(out_rd_wdata),
    .out_pc_rdata(out_pc_rdata), .out_pc_wdata(out_pc_wdata),
    .out_mem_addr(out_mem_addr), .out_mem_rmask(out_mem_rmask),
    .out_mem_wmask(out_mem_wmask), .out_mem_rdata(out_mem_rdata),
    .out_mem_wdata(out_mem_wdata), .check_en(check_en), .overflow(overflow),
    .order_err(order_err), .count(count)
  );

  // Retirement contents are derived from the order number.
  function automatic logic [31:0] f_insn(input logic [7:0] o);
    return {24'h00A013, o};
  endfunction
  function automatic logic [31:0] f_pc(input logic [7:0] o);
    return 32'h8000_0000 + {22'h0, o, 2'b00};
  endfunction
  function automatic logic [31:0] f_rd(input logic [7:0] o);
    return {o, ~o, o, 8'h5A};
  endfunction
  function automatic logic [3:0] f_rmask(input logic [7:0] o);
    return o[3:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_lane(input int i, input logic v, input logic [7:0] o);
    rvfi_valid[i] = v;
    if (v) begin
      rvfi_order[i*8 +: 8]          = o;
      rvfi_insn[i*32 +: 32]         = f_insn(o);
      rvfi_trap[i]                  = o[0];
      rvfi_rs1_addr[i*5 +: 5]       = o[4:0];
      rvfi_rs2_addr[i*5 +: 5]       = ~o[4:0];
      rvfi_rd_addr[i*5 +: 5]        = o[5:1];
      rvfi_rs1_rdata[i*XLEN +: XLEN] = {4{o}};
      rvfi_rs2_rdata[i*XLEN +: XLEN] = ~{4{o}};
      rvfi_rd_wdata[i*XLEN +: XLEN] = f_rd(o);
      rvfi_pc_rdata[i*XLEN +: XLEN] = f_pc(o);
      rvfi_pc_wdata[i*XLEN +: XLEN] = f_pc(o) + 32'd4;
      rvfi_mem_addr[i*XLEN +: XLEN] = 32'h1000_0000 | {24'h0, o};
      rvfi_mem_rmask[i*4 +: 4]      = f_rmask(o);
      rvfi_mem_wmask[i*4 +: 4]      = ~f_rmask(o);
      rvfi_mem_rdata[i*XLEN +: XLEN] = 32'hDEAD_0000 | {24'h0, o};
      rvfi_mem_wdata[i*XLEN +: XLEN] = 32'hBEEF_0000 | {24'h0, o};
    end else begin
      rvfi_order[i*8 +: 8]          = 'x;
      rvfi_insn[i*32 +: 32]         = 'x;
      rvfi_trap[i]                  = 1'bx;
      rvfi_rs1_addr[i*5 +: 5]       = 'x;
      rvfi_rs2_addr[i*5 +: 5]       = 'x;
      rvfi_rd_addr[i*5 +: 5]        = 'x;
      rvfi_rs1_rdata[i*XLEN +: XLEN] = 'x;
      rvfi_rs2_rdata[i*XLEN +: XLEN] = 'x;
      rvfi_rd_wdata[i*XLEN +: XLEN] = 'x;
      rvfi_pc_rdata[i*XLEN +: XLEN] = 'x;
      rvfi_pc_wdata[i*XLEN +: XLEN] = 'x;
      rvfi_mem_addr[i*XLEN +: XLEN] = 'x;
      rvfi_mem_rmask[i*4 +: 4]      = 'x;
      rvfi_mem_wmask[i*4 +: 4]      = 'x;
      rvfi_mem_rdata[i*XLEN +: XLEN] = 'x;
      rvfi_mem_wdata[i*XLEN +: XLEN] = 'x;
    end
  endtask

  task automatic drive(input logic v0, input logic [7:0] o0,
                       input logic v1, input logic [7:0] o1);
    set_lane(0, v0, o0);
    set_lane(1, v1, o1);
  endtask

  task automatic idle();
    drive(1'b0, 8'd0, 1'b0, 8'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [7:0] o);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_order"}, 64'(out_order), 64'(o));
    chk({tag, "_insn"}, 64'(out_insn), 64'(f_insn(o)));
    chk({tag, "_pc"}, 64'(out_pc_rdata), 64'(f_pc(o)));
  endtask

  task automatic do_reset();
    idle();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    out_ready = 1'b1;
    idle();
    tick();
    tick();

    // Reset state
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_order", 64'(out_order), 64'd0);
    chk("rst_insn", 64'(out_insn), 64'd0);
    chk("rst_pc", 64'(out_pc_rdata), 64'd0);
    chk("rst_rd_wdata", 64'(out_rd_wdata), 64'd0);
    chk("rst_check_en", 64'(check_en), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_order_err", 64'(order_err), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    resetn = 1'b1;
    tick();

    // Single lane, orders 0..9, two-cycle latency
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'(i), 1'b0, 8'd0);
      tick();
      if (i == 0) chk("t1_latency", 64'(out_valid), 64'd0);
      else        check_out("t1_seq", 8'(i - 1));
    end
    idle();
    tick();
    check_out("t1_last", 8'd9);
    chk("t1_rd_wdata", 64'(out_rd_wdata), 64'(f_rd(8'd9)));
    chk("t1_rmask", 64'(out_mem_rmask), 64'(f_rmask(8'd9)));
    tick();
    chk("t1_drained", 64'(out_valid), 64'd0);
    chk("t1_order_err", 64'(order_err), 64'd0);
    chk("t1_overflow", 64'(overflow), 64'd0);
    chk("t1_count", 64'(count), 64'd0);

    // Dual lane pairs (4,5) and (6,7)
    do_reset();
    drive(1'b1, 8'd4, 1'b1, 8'd5);
    tick();
    chk("t2_count_a", 64'(count), 64'd2);
    idle();
    tick();
    check_out("t2_o4", 8'd4);
    chk("t2_count_b", 64'(count), 64'd2);
    drive(1'b1, 8'd6, 1'b1, 8'd7);
    tick();
    check_out("t2_o5", 8'd5);
    chk("t2_count_peak", 64'(count), 64'd3);
    idle();
    tick();
    check_out("t2_o6", 8'd6);
    chk("t2_count_c", 64'(count), 64'd2);
    tick();
    check_out("t2_o7", 8'd7);
    chk("t2_count_d", 64'(count), 64'd1);
    tick();
    chk("t2_drained", 64'(out_valid), 64'd0);
    chk("t2_count_e", 64'(count), 64'd0);

    // Fill to DEPTH with out_ready low, then overflow
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 8'(2*k), 1'b1, 8'(2*k + 1));
      tick();
    end
    chk("t3_full_count", 64'(count), 64'd8);
    chk("t3_no_ovf_yet", 64'(overflow), 64'd0);
    chk("t3_head", 64'(out_order), 64'd0);
    drive(1'b1, 8'd8, 1'b1, 8'd9);
    tick();
    chk("t3_overflow", 64'(overflow), 64'd1);
    chk("t3_count_hold", 64'(count), 64'd8);
    check_out("t3_hold", 8'd0);
    idle();
    out_ready = 1'b1;
    for (int k = 1; k < 8; k++) begin
      tick();
      check_out("t3_drain", 8'(k));
    end
    tick();
    chk("t3_drained", 64'(out_valid), 64'd0);
    chk("t3_count_end", 64'(count), 64'd0);
    chk("t3_ovf_sticky", 64'(overflow), 64'd1);

    // Full buffer with simultaneous pop and single-lane push
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 8'(10 + 2*k), 1'b1, 8'(11 + 2*k));
      tick();
    end
    chk("t4_full", 64'(count), 64'd8);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 8'(18 + k), 1'b0, 8'd0);
      tick();
      chk("t4_count", 64'(count), 64'd8);
      check_out("t4_seq", 8'(11 + k));
    end
    chk("t4_overflow", 64'(overflow), 64'd0);

    // check_en at order 20, held through a stall
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 8'd18, 1'b1, 8'd19);
    tick();
    drive(1'b1, 8'd20, 1'b1, 8'd21);
    tick();
    idle();
    check_out("t5_o18", 8'd18);
    chk("t5_chk18", 64'(check_en), 64'd0);
    tick();
    check_out("t5_o19", 8'd19);
    chk("t5_chk19", 64'(check_en), 64'd0);
    tick();
    check_out("t5_o20", 8'd20);
    chk("t5_chk20", 64'(check_en), 64'd1);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_out("t5_stall", 8'd20);
      chk("t5_chk_stall", 64'(check_en), 64'd1);
    end
    out_ready = 1'b1;
    tick();
    check_out("t5_o21", 8'd21);
    chk("t5_chk21", 64'(check_en), 64'd0);

    // Order wrap 254,255,0 then a gap to 2; lane 1 alone carries 255
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 8'd254, 1'b0, 8'd0);
    tick();
    drive(1'b0, 8'd0, 1'b1, 8'd255);
    tick();
    check_out("t6_o254", 8'd254);
    drive(1'b1, 8'd0, 1'b0, 8'd0);
    tick();
    check_out("t6_o255", 8'd255);
    chk("t6_err_a", 64'(order_err), 64'd0);
    drive(1'b1, 8'd2, 1'b0, 8'd0);
    tick();
    check_out("t6_o0", 8'd0);
    chk("t6_err_b", 64'(order_err), 64'd0);
    drive(1'b1, 8'd3, 1'b0, 8'd0);
    tick();
    check_out("t6_o2", 8'd2);
    chk("t6_err_c", 64'(order_err), 64'd0);
    drive(1'b1, 8'd4, 1'b0, 8'd0);
    tick();
    check_out("t6_o3", 8'd3);
    chk("t6_err_set", 64'(order_err), 64'd1);
    out_ready = 1'b0;
    drive(1'b1, 8'd5, 1'b1, 8'd6);
    tick();
    idle();
    chk("t6_pre_rst_valid", 64'(out_valid), 64'd1);
    chk("t6_pre_rst_count", 64'(count), 64'd4);

    // Asynchronous reset between clock edges
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_arst_valid", 64'(out_valid), 64'd0);
    chk("t6_arst_order", 64'(out_order), 64'd0);
    chk("t6_arst_insn", 64'(out_insn), 64'd0);
    chk("t6_arst_pc", 64'(out_pc_rdata), 64'd0);
    chk("t6_arst_count", 64'(count), 64'd0);
    chk("t6_arst_order_err", 64'(order_err), 64'd0);
    chk("t6_arst_check_en", 64'(check_en), 64'd0);
    out_ready = 1'b1;
    tick();
    resetn = 1'b1;
    tick();
    tick();
    chk("t6_post_valid", 64'(out_valid), 64'd0);
    chk("t6_post_count", 64'(count), 64'd0);
    chk("t6_post_err", 64'(order_err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rvfi_channel_serializer.md
Name: rvfi_channel_serializer

Overview:
- Collects up to NRET retirements per cycle from a superscalar core's RVFI and replays them as a single-channel RVFI stream, one retirement per cycle, preserving retire order.
- Lets single-channel checkers (instruction, PC, register checks) run on multi-retire cores without per-channel instantiation.
- Also drives the checker `enable` strobe, asserted when the emitted retirement matches a configured order number.
- Flags buffer overflow and order discontinuities.

Parameters:
- NRET, 2, number of input retirement channels (1..4)
- XLEN, 32, register width (32 or 64)
- DEPTH, 8, buffer depth in retirements; power of two, >= NRET
- CHECK_ORDER, 20, rvfi_order value at which check_en is raised

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- rvfi_valid/order/insn/trap/rs1_addr/rs2_addr/rs1_rdata/rs2_rdata/rd_addr/rd_wdata/pc_rdata/pc_wdata/mem_addr/mem_rmask/mem_wmask/mem_rdata/mem_wdata  in  NRET x {1,8,32,1,5,5,XLEN,XLEN,5,XLEN,XLEN,XLEN,XLEN,XLEN/8,XLEN/8,XLEN,XLEN}  multi-channel retirement buses, channel i at slice i*w +: w
- out_ready  in  1  downstream accepts current output
- out_* (same 17 fields)  out  single-channel widths  serialized retirement; out_valid qualifies the rest
- check_en  out  1  high while the output holds order == CHECK_ORDER
- overflow  out  1  sticky: a retirement group was dropped
- order_err  out  1  sticky: consecutive emitted orders differed by != 1 (mod 256)
- count  out  $clog2(DEPTH)+1  current buffer occupancy

Behaviour:
- Reset (async, resetn low): out_valid=0, all out_* fields=0, check_en=0, overflow=0, order_err=0, count=0, rd/wr pointers=0, expected-order register invalid. Reset mid-operation discards buffered entries immediately.
- Packet: all fields of one channel concatenated. Width = 56 + 8*XLEN + XLEN/4 (320 at XLEN=32).
- Push:
  - Each cycle, valid lanes are compacted in ascending lane index (lane 0 oldest).
  - The P = popcount(rvfi_valid) packets are written at wr_ptr .. wr_ptr+P-1 mod DEPTH.
- Space rule: push accepted iff P <= DEPTH - count + pop, where pop = out_valid && out_ready this cycle (pop and push in the same cycle are allowed when full). Otherwise the whole group is dropped, overflow set, and pointers are unchanged by the push.
- Output stage:
  - Registered. When the output is empty or popping and the buffer is non-empty, the head entry loads into out_* next cycle with out_valid=1.
  - Latency from rvfi_valid to out_valid is 2 cycles minimum.
  - With out_valid=1 and out_ready=0, out_* hold stable.
  - count includes the entry held in the output register.
- Bypass: none; an empty buffer still takes the 2-cycle path.
- check_en = out_valid && out_order == CHECK_ORDER[7:0], combinational from registered outputs.
- Order check:
  - On each pop, if the expected-order register is valid and out_order != expected, set order_err.
  - Then expected = out_order + 1 (8-bit wrap, 255 -> 0 legal) and mark it valid.
- Pointer wrap: rd_ptr/wr_ptr are $clog2(DEPTH) bits, natural wrap; full/empty decided by count, never by pointer equality.
- rvfi_valid=0 lanes: their data is ignored (X-tolerant).
- Sticky flags clear only on reset.

Decomposition:
- Shared package rvfi_pkg: packet field widths/offsets as localparams, a pack/unpack function pair keyed on XLEN, popcount function.
- One sub-module, rvfi_multi_push_fifo (DEPTH x packet storage, up to NRET writes and 1 read per cycle, count output).
- Compaction, output register, order/check logic stay in the top.

Test Plan:
- NRET=2, one retirement per cycle on lane 0 (orders 0..9), out_ready=1 -> out_order 0..9 on consecutive cycles starting 2 cycles after the first push; order_err=0, overflow=0.
- Both lanes valid with orders (4,5),(6,7) over 2 cycles, out_ready=1 -> outputs 4,5,6,7 in order; count peaks at 3.
- out_ready=0, push 4 pairs (8 entries, DEPTH=8) -> count=8. Next pair -> overflow=1, count stays 8. Then out_ready=1 -> exactly the first 8 orders emerge.
- Full buffer, out_ready=1, single lane push each cycle -> no overflow; count stays 8.
- Lane orders 18,19 then 20,21 -> check_en high exactly the cycle out_order=20 is presented. Stall out_ready=0 for 3 cycles there -> check_en stays high 3 cycles, and out_insn/out_pc_rdata remain stable.
- Orders 254,255,0,2 -> order_err stays 0 through the wrap and becomes 1 after 2 pops. Assert resetn low mid-stream -> all outputs 0 asynchronously, and order_err clears.
